// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with standard or first-word-fall-through read mode, occupancy
// count, programmable almost-full/almost-empty thresholds, error pulses and flush.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DATA_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  output logic                          almost_full,
  output logic                          overflow,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          almost_empty,
  output logic                          underflow,
  output logic [$clog2(DATA_DEPTH):0]   count
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] AF_THRES = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THRES = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // The extra pointer MSB separates a full wrap from the empty case.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign almost_full  = (count >= AF_THRES);
  assign almost_empty = (count <= AE_THRES);

  assign wr_acc = wr_en && !full && !clr;
  assign rd_acc = rd_en && !empty && !clr;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_acc && !rd_acc) begin
        count <= count + PTR_ONE;
      end else if (rd_acc && !wr_acc) begin
        count <= count - PTR_ONE;
      end
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem[rd_ptr[AW-1:0]];
      assign rd_valid = !empty;
    end else begin : g_std
      // Registered read port; rd_data keeps the last popped word between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else if (clr) begin
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised and directed bench for sync_fifo_ctrl: a standard-mode and an FWFT
// instance share one stimulus stream and are checked against a queue model.
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF_S  = 7;
  localparam int AE_S  = 1;
  localparam int AF_F  = 6;
  localparam int AE_F  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;

  logic          s_full, s_afull, s_ovf, s_valid, s_empty, s_aempty, s_unf;
  logic [DW-1:0] s_data;
  logic [3:0]    s_count;
  logic          f_full, f_afull, f_ovf, f_valid, f_empty, f_aempty, f_unf;
  logic [DW-1:0] f_data;
  logic [3:0]    f_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          exp_ovf;
  logic          exp_unf;
  logic          exp_svalid;
  logic [DW-1:0] exp_sdata;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(0),
                   .AF_LEVEL(AF_S), .AE_LEVEL(AE_S)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_afull), .overflow(s_ovf), .rd_en(rd_en),
    .rd_data(s_data), .rd_valid(s_valid), .empty(s_empty),
    .almost_empty(s_aempty), .underflow(s_unf), .count(s_count)
  );

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(1),
                   .AF_LEVEL(AF_F), .AE_LEVEL(AE_F)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(f_full), .almost_full(f_afull), .overflow(f_ovf), .rd_en(rd_en),
    .rd_data(f_data), .rd_valid(f_valid), .empty(f_empty),
    .almost_empty(f_aempty), .underflow(f_unf), .count(f_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    exp_ovf    = 1'b0;
    exp_unf    = 1'b0;
    exp_svalid = 1'b0;
    exp_sdata  = '0;
  endtask

  // Behavioural model of one clock edge, working from the pre-edge occupancy.
  task automatic modelEdge(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete();
      exp_ovf    = 1'b0;
      exp_unf    = 1'b0;
      exp_svalid = 1'b0;
    end else begin
      exp_ovf = w && was_full;
      exp_unf = r && was_empty;
      if (r && !was_empty) begin
        exp_sdata  = q.pop_front();
        exp_svalid = 1'b1;
      end else begin
        exp_svalid = 1'b0;
      end
      if (w && !was_full) q.push_back(d);
    end
  endtask

  task automatic checkAll();
    int n;
    n = q.size();
    checkOutput("s_count",  32'(s_count),  32'(n));
    checkOutput("s_full",   32'(s_full),   32'(n == DEPTH));
    checkOutput("s_empty",  32'(s_empty),  32'(n == 0));
    checkOutput("s_afull",  32'(s_afull),  32'(n >= AF_S));
    checkOutput("s_aempty", 32'(s_aempty), 32'(n <= AE_S));
    checkOutput("s_ovf",    32'(s_ovf),    32'(exp_ovf));
    checkOutput("s_unf",    32'(s_unf),    32'(exp_unf));
    checkOutput("s_valid",  32'(s_valid),  32'(exp_svalid));
    checkOutput("s_data",   32'(s_data),   32'(exp_sdata));
    checkOutput("f_count",  32'(f_count),  32'(n));
    checkOutput("f_full",   32'(f_full),   32'(n == DEPTH));
    checkOutput("f_empty",  32'(f_empty),  32'(n == 0));
    checkOutput("f_afull",  32'(f_afull),  32'(n >= AF_F));
    checkOutput("f_aempty", 32'(f_aempty), 32'(n <= AE_F));
    checkOutput("f_ovf",    32'(f_ovf),    32'(exp_ovf));
    checkOutput("f_unf",    32'(f_unf),    32'(exp_unf));
    checkOutput("f_valid",  32'(f_valid),  32'(n != 0));
    if (n != 0) checkOutput("f_data", 32'(f_data), 32'(q[0]));
  endtask

  task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr     = c;
    @(posedge clk);
    modelEdge(w, d, r, c);
    #1;
    checkAll();
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fill to full and overflow");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] drain and underflow");
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] steady occupancy with wrap");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(8'h20 + i), 1'b1, 1'b0);

    $display("[TB] simultaneous access at full and empty");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] fall-through of single word");
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] flush with concurrent requests");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h7F, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 55), DW'($urandom),
                    1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 29) == 0));
    end

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, DW'(8'hC0 + i), 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hCF, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO for buffering data between producer and consumer stages on one clock domain. Generalises the basic synchronous FIFO with:
- selectable standard or first-word-fall-through (FWFT) read mode
- an occupancy count
- programmable almost-full and almost-empty thresholds
- overflow and underflow error pulses
- a synchronous flush

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
DATA_DEPTH, 8, number of entries; power of two, >=2
FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through
AF_LEVEL, DATA_DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DATA_DEPTH
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; legal range 0..DATA_DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
clr  in  1  synchronous flush, active-high
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
full  out  1  no free entry
almost_full  out  1  count >= AF_LEVEL
overflow  out  1  one-cycle pulse: previous-cycle write was rejected
rd_en  in  1  read request (FWFT: acknowledge of head word)
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data is valid (see Behaviour)
empty  out  1  no stored entry
almost_empty  out  1  count <= AE_LEVEL
underflow  out  1  one-cycle pulse: previous-cycle read was rejected
count  out  $clog2(DATA_DEPTH)+1  current occupancy, 0..DATA_DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - write/read pointers, count, overflow, underflow, rd_valid (standard mode) and rd_data register all go to 0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents.
- Pointers are $clog2(DATA_DEPTH)+1 bits; the extra MSB distinguishes wrap.
  - empty = pointers equal.
  - full = MSBs differ and low bits equal.
  - Pointers wrap naturally modulo 2*DATA_DEPTH.
- count is a register updated alongside the pointers:
  - +1 on accepted write only
  - -1 on accepted read only
  - unchanged when both are accepted
  - count always equals wr_ptr - rd_ptr.
- almost_full and almost_empty are combinational from registered count only.
- Write accept = wr_en && !full && !clr.
  - Word stored at wr_ptr low bits; wr_ptr increments.
- Read accept = rd_en && !empty && !clr.
  - rd_ptr increments.
- Simultaneous write and read:
  - When neither full nor empty, both are accepted.
  - When full, the write is rejected even if a read is accepted the same cycle.
  - When empty, the read is rejected; the write is accepted.
- Rejected requests:
  - wr_en && full && !clr -> overflow=1 for exactly the next cycle.
  - rd_en && empty && !clr -> underflow=1 for exactly the next cycle.
  - No state changes on a rejected request.
- Standard mode (FWFT=0):
  - On accepted read, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the next edge.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - A written word is visible on rd_data the cycle after the write edge.
  - An accepted rd_en pops the head; the next word is shown after that edge.
  - The rd_data register is unused.
- clr (synchronous, highest priority over wr_en/rd_en):
  - Next edge: pointers and count go to 0; overflow, underflow and rd_valid go to 0.
  - Storage is unchanged.
  - Requests in the clr cycle are neither accepted nor flagged.
- Full and empty are never both 1. count==DATA_DEPTH iff full; count==0 iff empty.

Test Plan:
1. DEPTH=8, FWFT=0: reset, then write 0x01..0x08 on consecutive cycles.
   - full=1 after the 8th edge; count=8; almost_full=1 from count=7.
   - A 9th write gives overflow=1 for one cycle; contents unchanged.
2. From full, assert rd_en for 8 cycles.
   - rd_data = 0x01..0x08, each 1 cycle after its rd_en, with rd_valid=1.
   - empty=1 after the last read; almost_empty=1 at count<=1.
   - A 9th read gives underflow=1 and rd_valid=0.
3. Count 4, wr_en and rd_en asserted together for 20 cycles with an incrementing pattern.
   - count stays 4; pointers wrap at least twice; read sequence is in order with no loss.
4. Full plus simultaneous wr_en/rd_en.
   - Read accepted, write rejected, overflow=1; count goes 8 -> 7.
   - Empty plus simultaneous wr_en/rd_en: write accepted, underflow=1, count 0 -> 1.
5. FWFT=1: write 0xA5 into an empty FIFO.
   - Next cycle rd_valid=1, rd_data=0xA5 with no rd_en.
   - rd_en pops it; following cycle rd_valid=0.
6. Count 5, pulse clr together with wr_en and rd_en.
   - Next cycle count=0, empty=1, no overflow/underflow.
   - Assert rst_n low mid-stream asynchronously (between edges): all outputs are at reset values immediately.
